// File: rtl/seg14_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg14_scan_ctrl
// Brief    : Multi-digit 14-segment scan controller with a double-buffered
//            pattern store; new content is published only at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module seg14_scan_ctrl #(
   parameter int DIGITS = 12,
   parameter int DWELL  = 16,
   parameter int BLANK  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [3:0]        wr_addr,
   input  logic [13:0]       wr_data,
   input  logic              commit,
   output logic              commit_pending,
   output logic [DIGITS-1:0] sel,
   output logic [13:0]       segm,
   output logic              frame_start
);

   localparam int                c_DW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int                c_CW         = $clog2(DWELL + 1);
   localparam logic [c_DW-1:0]   c_DIGIT_LAST = c_DW'(DIGITS - 1);
   localparam logic [c_CW-1:0]   c_DWELL_LAST = c_CW'(DWELL - 1);
   localparam logic [4:0]        c_DIGITS     = 5'(DIGITS);
   localparam logic [DIGITS-1:0] c_SEL_ONE    = DIGITS'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   state_t            r_state;
   logic [c_DW-1:0]   r_digit;
   logic [c_CW-1:0]   r_dwell;
   logic [13:0]       r_back  [DIGITS];
   logic [13:0]       r_front [DIGITS];
   logic              r_pending;
   logic [DIGITS-1:0] r_sel;
   logic [13:0]       r_segm;
   logic              r_frame_start;

   state_t            w_state_nxt;
   logic [c_DW-1:0]   w_digit_nxt;
   logic [c_CW-1:0]   w_dwell_nxt;
   logic              w_wr_fire;
   logic              w_swap;
   logic              w_blank;
   logic              w_drive;
   logic [13:0]       w_segm_nxt;

   assign wr_ready       = !rst && !r_pending;
   assign commit_pending = r_pending;
   assign sel            = r_sel;
   assign segm           = r_segm;
   assign frame_start    = r_frame_start;

   assign w_wr_fire = wr_valid && wr_ready;
   assign w_swap    = r_pending &&
                      ((r_state == S_IDLE) ||
                       ((r_digit == c_DIGIT_LAST) && (r_dwell == c_DWELL_LAST)));

   // Next scan position; outputs are registered from it so they describe the
   // position the counters hold in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_digit_nxt = r_digit;
      w_dwell_nxt = r_dwell;
      case (r_state)
         S_IDLE: begin
            w_digit_nxt = '0;
            w_dwell_nxt = '0;
            if (enable) begin
               w_state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            if (!enable) begin
               w_state_nxt = S_IDLE;
               w_digit_nxt = '0;
               w_dwell_nxt = '0;
            end else if (r_dwell == c_DWELL_LAST) begin
               w_dwell_nxt = '0;
               w_digit_nxt = (r_digit == c_DIGIT_LAST) ? '0 : r_digit + 1'b1;
            end else begin
               w_dwell_nxt = r_dwell + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_digit_nxt = '0;
            w_dwell_nxt = '0;
         end
      endcase
   end

   generate
      if (BLANK == 0) begin : g_no_blank
         assign w_blank = 1'b0;
      end else begin : g_blank
         assign w_blank = (w_dwell_nxt < c_CW'(BLANK));
      end
   endgenerate

   // A swap on this edge must already be visible in the pattern it launches.
   assign w_drive    = (w_state_nxt == S_SCAN) && !w_blank;
   assign w_segm_nxt = w_swap ? r_back[w_digit_nxt] : r_front[w_digit_nxt];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_digit       <= '0;
         r_dwell       <= '0;
         r_pending     <= 1'b0;
         r_sel         <= '0;
         r_segm        <= '0;
         r_frame_start <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            r_back[i]  <= '0;
            r_front[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_digit <= w_digit_nxt;
         r_dwell <= w_dwell_nxt;

         if (w_wr_fire && ({1'b0, wr_addr} < c_DIGITS)) begin
            r_back[wr_addr[c_DW-1:0]] <= wr_data;
         end

         if (w_swap) begin
            r_front   <= r_back;
            r_pending <= 1'b0;
         end else if (commit && !r_pending) begin
            r_pending <= 1'b1;
         end

         r_sel         <= w_drive ? (c_SEL_ONE << w_digit_nxt) : '0;
         r_segm        <= w_drive ? w_segm_nxt : '0;
         r_frame_start <= (w_state_nxt == S_SCAN) && (w_digit_nxt == '0) &&
                          (w_dwell_nxt == '0);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg14_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg14_scan_ctrl
// Brief    : Scoreboard bench for seg14_scan_ctrl; two instances (default and
//            4-digit/no-blank) share stimulus and are compared to a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg14_scan_ctrl;

   localparam int A_DIGITS = 12, A_DWELL = 16, A_BLANK = 2;
   localparam int B_DIGITS = 4,  B_DWELL = 3,  B_BLANK = 0;

   typedef struct packed {
      logic [15:0] sel;
      logic [13:0] segm;
      logic        fs;
      logic        pend;
   } exp_t;

   // Model state: position is simply the cycle count into the current frame.
   typedef struct packed {
      bit               scanning;
      int               t;
      bit               pending;
      logic [15:0][13:0] back;
      logic [15:0][13:0] front;
   } mstate_t;

   logic        clk = 1'b0;
   logic        rst, enable, wr_valid, commit;
   logic [3:0]  wr_addr;
   logic [13:0] wr_data;

   logic        wr_ready_a, pend_a, fs_a;
   logic [11:0] sel_a;
   logic [13:0] segm_a;
   logic        wr_ready_b, pend_b, fs_b;
   logic [3:0]  sel_b;
   logic [13:0] segm_b;

   int      checks = 0;
   int      errors = 0;
   int      cyc    = 0;
   mstate_t ma, mb;
   exp_t    qa[$];
   exp_t    qb[$];
   exp_t    mon_ea, mon_eb;

   seg14_scan_ctrl #(.DIGITS(A_DIGITS), .DWELL(A_DWELL), .BLANK(A_BLANK)) dut_a (
      .clk(clk), .rst(rst), .enable(enable),
      .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .commit_pending(pend_a),
      .sel(sel_a), .segm(segm_a), .frame_start(fs_a)
   );

   seg14_scan_ctrl #(.DIGITS(B_DIGITS), .DWELL(B_DWELL), .BLANK(B_BLANK)) dut_b (
      .clk(clk), .rst(rst), .enable(enable),
      .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .commit_pending(pend_b),
      .sel(sel_b), .segm(segm_b), .frame_start(fs_b)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Behavioural step for one clock edge, using the inputs sampled at that edge.
   task automatic model_step(input int nd, input int ndw, input int nbl,
                             input mstate_t m_in, output mstate_t m_out, output exp_t e);
      mstate_t m;
      int      frame, p, d, c;
      bit      swap;
      m     = m_in;
      frame = nd * ndw;
      if (rst) begin
         m = '0;
      end else begin
         swap = m.pending && (!m.scanning || (m.t == frame - 1));
         if (wr_valid && !m.pending && (int'(wr_addr) < nd)) m.back[wr_addr] = wr_data;
         if (swap) begin
            m.front   = m.back;
            m.pending = 1'b0;
         end else if (commit && !m.pending) begin
            m.pending = 1'b1;
         end
         if (!m.scanning) begin
            if (enable) begin
               m.scanning = 1'b1;
               m.t        = 0;
            end
         end else if (!enable) begin
            m.scanning = 1'b0;
            m.t        = 0;
         end else begin
            m.t = (m.t + 1) % frame;
         end
      end
      e      = '0;
      e.pend = m.pending;
      if (m.scanning) begin
         p = m.t;
         d = p / ndw;
         c = p % ndw;
         if (c >= nbl) begin
            e.sel  = 16'h0001 << d;
            e.segm = m.front[d];
         end
         e.fs = (p == 0);
      end
      m_out = m;
   endtask

   task automatic tick();
      exp_t ea, eb;
      @(posedge clk);
      model_step(A_DIGITS, A_DWELL, A_BLANK, ma, ma, ea);
      model_step(B_DIGITS, B_DWELL, B_BLANK, mb, mb, eb);
      qa.push_back(ea);
      qb.push_back(eb);
      cyc++;
      #1;
   endtask

   // Monitor: every cycle the DUTs present a fresh output word to compare.
   always @(negedge clk) begin
      if (qa.size() != 0 && qb.size() != 0) begin
         mon_ea = qa.pop_front();
         mon_eb = qb.pop_front();
         chk("a.sel",      32'(sel_a),      32'(mon_ea.sel));
         chk("a.segm",     32'(segm_a),     32'(mon_ea.segm));
         chk("a.fstart",   32'(fs_a),       32'(mon_ea.fs));
         chk("a.pending",  32'(pend_a),     32'(mon_ea.pend));
         chk("a.wr_ready", 32'(wr_ready_a), 32'(!rst && !mon_ea.pend));
         chk("b.sel",      32'(sel_b),      32'(mon_eb.sel));
         chk("b.segm",     32'(segm_b),     32'(mon_eb.segm));
         chk("b.fstart",   32'(fs_b),       32'(mon_eb.fs));
         chk("b.pending",  32'(pend_b),     32'(mon_eb.pend));
         chk("b.wr_ready", 32'(wr_ready_b), 32'(!rst && !mon_eb.pend));
      end
   end

   initial begin
      bit found;
      rst = 1'b1; enable = 1'b0; wr_valid = 1'b0; commit = 1'b0;
      wr_addr = '0; wr_data = '0;
      ma = '0; mb = '0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // Free-running scan over cleared buffers.
      enable = 1'b1;
      repeat (2 * 192 + 10) tick();

      // Load all digits, then commit mid-frame.
      for (int i = 0; i < 12; i++) begin
         wr_valid = 1'b1;
         wr_addr  = 4'(i);
         wr_data  = 14'h3B6C ^ 14'(i * 14'h0457);
         tick();
      end
      wr_valid = 1'b0;
      repeat (50) tick();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      repeat (2 * 192) tick();

      // Write+commit together, then keep writing while the commit is pending.
      wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 14'h2A55; commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int i = 0; i < 250; i++) begin
         wr_addr = 4'($urandom_range(0, 11));
         wr_data = 14'($urandom);
         tick();
      end
      wr_valid = 1'b0;
      repeat (200) tick();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      repeat (400) tick();

      // Out-of-range address, then write and commit in one cycle.
      wr_valid = 1'b1; wr_addr = 4'd13; wr_data = 14'h1FFF;
      tick();
      wr_addr = 4'd2; wr_data = 14'h0C3A; commit = 1'b1;
      tick();
      wr_valid = 1'b0; commit = 1'b0;
      repeat (400) tick();

      // Drop enable at digit 5 / slot cycle 7 with a commit pending.
      wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 14'h1234;
      tick();
      wr_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (ma.scanning && ma.t == 10) found = 1'b1;
         else tick();
      end
      commit = 1'b1;
      tick();
      commit = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (ma.scanning && ma.t == 5 * A_DWELL + 7) found = 1'b1;
         else tick();
      end
      chk("reach_digit5_cnt7", 32'(found), 32'd1);
      enable = 1'b0;
      repeat (6) tick();
      enable = 1'b1;
      repeat (200) tick();

      // Reset mid-frame with a commit pending, then publish the cleared back buffer.
      wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 14'h3FFF; commit = 1'b1;
      tick();
      wr_valid = 1'b0; commit = 1'b0;
      repeat (20) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      repeat (400) tick();

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         wr_valid = ($urandom_range(0, 1) == 1);
         wr_addr  = 4'($urandom_range(0, 15));
         wr_data  = 14'($urandom);
         commit   = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 149) == 0) enable = !enable;
         rst      = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 1'b0; wr_valid = 1'b0; commit = 1'b0;
      repeat (2) tick();

      @(negedge clk);
      #1;
      chk("queue_a_drained", 32'(qa.size()), 32'd0);
      chk("queue_b_drained", 32'(qb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg14_scan_ctrl.md
# seg14_scan_ctrl

Scan controller for the 12-digit, 14-segment display. It holds a double-buffered 12-character segment-pattern store, written through a valid/ready port. It time-multiplexes the digits with a programmable dwell and an anti-ghosting blank interval, and it swaps in new message content only at frame boundaries. It sits between any message source and the physical `sel`/`segm` display pins, replacing hard-wired per-digit patterns.

## Interface

Parameters:
- `DIGITS`, default 12: number of digits scanned. Range 2..16; `sel` width follows it.
- `DWELL`, default 16: clocks per digit slot, blank interval included. Must be ≥ `BLANK`+1.
- `BLANK`, default 2: clocks at the start of each slot with all outputs low. May be 0.

Ports (clock and reset first):
- `clk` input, 1 bit: single clock. All logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: scanning enable, level-sensitive.
- `wr_valid` input, 1 bit: back-buffer write request.
- `wr_ready` output, 1 bit: back buffer accepts a write this cycle.
- `wr_addr` input, 4 bits: digit index of the write.
- `wr_data` input, 14 bits: segment pattern, same bit order as `segm`.
- `commit` input, 1 bit: single-cycle request to publish the back buffer.
- `commit_pending` output, 1 bit: a publish is waiting for a frame boundary.
- `sel` output, `DIGITS` bits: one-hot digit select, active high.
- `segm` output, 14 bits: segment drive, active high.
- `frame_start` output, 1 bit: pulse in the first cycle of each frame.

## Operation

- Storage: `back[DIGITS]` and `front[DIGITS]`, each entry 14 bits. Reset clears both to 0.
- Write handshake:
  - A write is accepted on a cycle where `wr_valid && wr_ready`. At that edge, `back[wr_addr] <= wr_data`.
  - If `wr_addr` ≥ `DIGITS`, the write is accepted and discarded.
  - `wr_ready = !rst && !commit_pending`.
- Commit:
  - `commit` sampled high while `commit_pending`=0 sets `commit_pending`.
  - `commit` while `commit_pending`=1 is ignored.
  - If a write and `commit` occur in the same cycle, the write is accepted and becomes part of the commit.
- Swap: copy all entries at once, `front <= back`, and clear `commit_pending`. The back buffer keeps its contents. The swap occurs:
  - at the last-cycle edge of a frame (`digit_idx`=`DIGITS`-1, `dwell_cnt`=`DWELL`-1), or
  - on any edge while in IDLE.
- State machine:
  - IDLE: counters are 0 and outputs are 0. If `enable`=1, go to SCAN with `digit_idx`=0 and `dwell_cnt`=0.
  - SCAN: `dwell_cnt` increments and wraps at `DWELL`-1. On that wrap, `digit_idx` increments and wraps at `DIGITS`-1. If `enable`=0, go to IDLE on the next edge, abandoning the frame mid-slot.
- Outputs (registered, describing the current position):
  - If `dwell_cnt` < `BLANK`: `sel`=0 and `segm`=0.
  - Otherwise: `sel`=1<<`digit_idx` and `segm`=`front[digit_idx]`.
  - `frame_start`=1 only when in SCAN with `digit_idx`=0 and `dwell_cnt`=0.
- Reset: all counters 0; state IDLE; `sel`=0, `segm`=0, `frame_start`=0, `commit_pending`=0, `wr_ready`=0.
  - Reset mid-frame or mid-commit discards the pending swap and both buffers.

## Timing

- Frame length is `DIGITS`×`DWELL` clocks, 192 at the defaults.
- Each digit is driven for `DWELL`-`BLANK` clocks, 14 at the defaults.
- Enable latency:
  - `enable` high sampled at edge E: the first `frame_start` cycle follows E.
  - With `BLANK`=0, `sel` is `0x001` in that same cycle.
- Disable latency: `enable` low sampled at edge E gives `sel`=0 and `segm`=0 in the cycle after E.
- Commit-to-display latency: `commit_pending` rises 1 cycle after `commit`.
  - New content appears first at the digit-0 drive of the next frame.
  - Worst case is 1 frame + 1 cycle. In IDLE it is 2 cycles.
- `wr_ready` falls in the cycle after `commit` is accepted, and rises in the cycle after the swap.
- `sel` has no overlap between adjacent digits: with `BLANK`≥1 there is at least one all-zero cycle between them.

## Test plan

- Reset, then `enable`=1 with defaults → `frame_start` every 192 cycles. `sel` cycles `0x001`..`0x800`, each value held 14 cycles after a 2-cycle zero gap. `segm`=0 throughout, since buffers are cleared.
- Write digits 0..11 with `0x3B6C`..., then `commit` mid-frame → `front` is unchanged until the frame ends. The next frame shows digit 0 = `0x3B6C`. `commit_pending` and `wr_ready` change exactly as specified.
- Hold `wr_valid`=1 during `commit_pending` → no write is accepted. After the swap, the held write lands in `back` only and is not displayed until the next commit.
- Write with `wr_addr`=13 → accepted, no buffer entry changes. Write and `commit` in the same cycle → the written value is included in the swap.
- Drop `enable` at digit 5, `dwell_cnt` 7 → outputs are 0 the next cycle. A pending commit in IDLE swaps within 2 cycles. Re-enable → the frame restarts at digit 0 with `frame_start`.
- Assert `rst` mid-frame with a pending commit → one cycle later all outputs and `commit_pending` are 0 and the buffers read 0. `DIGITS`=4, `DWELL`=3, `BLANK`=0 → `sel` is never 0 during SCAN and the frame is 12 cycles.
